// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - multi-cycle bit-serial subtractor (diff = a - b) with start/busy/done handshake
module serial_sub #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_d, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, ovf_q, zero_q;

  logic [BPC-1:0]   slice_d;
  logic [BPC:0]     br_c;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             accept;
  logic             last;

  // A new operation can be taken whenever we are not mid-run (IDLE or DONE).
  assign accept = (state_q != S_RUN) && start;
  assign last   = (cnt_q == CW'(N - 1));

  // Full-subtractor borrow chain across the BPC low bits of the shifted operands
  always_comb begin
    br_c[0] = br_q;
    slice_d = '0;
    for (int j = 0; j < BPC; j++) begin
      slice_d[j] = a_q[j] ^ b_q[j] ^ br_c[j];
      br_c[j+1]  = (~a_q[j] & b_q[j]) | (~(a_q[j] ^ b_q[j]) & br_c[j]);
    end
  end

  assign br_d = br_c[BPC];

  generate
    if (BPC < WIDTH) begin : g_shift
      // Partial result accumulates from the MSB side; the oldest bits settle at the bottom.
      logic [WIDTH-BPC-1:0] acc_q;

      assign res_d = {slice_d, acc_q};
      assign a_d   = {{BPC{1'b0}}, a_q[WIDTH-1:BPC]};
      assign b_d   = {{BPC{1'b0}}, b_q[WIDTH-1:BPC]};

      // Result accumulator: cleared on accept, shifted once per RUN cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
        end else if (accept) begin
          acc_q <= '0;
        end else if (state_q == S_RUN) begin
          acc_q <= res_d[WIDTH-1:BPC];
        end
      end
    end else begin : g_wide
      // Whole word retired in a single RUN cycle; nothing to accumulate.
      assign res_d = slice_d;
      assign a_d   = '0;
      assign b_d   = '0;
    end
  endgenerate

  // Signed overflow uses the captured operand MSBs since the shift registers lose them.
  assign ovf_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after N cycles, DONE -> RUN/IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, per-cycle shift/borrow update, and result registers loaded on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == S_RUN) begin
      a_q   <= a_d;
      b_q   <= b_d;
      br_q  <= br_d;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        diff_q   <= res_d;
        borrow_q <= br_d;
        ovf_q    <= ovf_d;
        zero_q   <= (res_d == '0);
      end
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub at BITS_PER_CYCLE 1, 4 and 64
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       start_s, busy_s, done_s, bo_s, ov_s, zr_s;
  logic [2:0][63:0] a_s, b_s, diff_s;

  int checks   = 0;
  int failures = 0;
  int nv [3]   = '{64, 16, 1};
  int rn [3]   = '{120, 300, 1500};

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        zr;
  } vec_t;

  vec_t vecs [8];

  serial_sub #(.WIDTH(64), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .diff(diff_s[0]),
    .borrow_out(bo_s[0]), .overflow(ov_s[0]), .zero(zr_s[0])
  );

  serial_sub #(.WIDTH(64), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .diff(diff_s[1]),
    .borrow_out(bo_s[1]), .overflow(ov_s[1]), .zero(zr_s[1])
  );

  serial_sub #(.WIDTH(64), .BITS_PER_CYCLE(64)) u_bpc64 (
    .clk(clk), .rst(rst), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .diff(diff_s[2]),
    .borrow_out(bo_s[2]), .overflow(ov_s[2]), .zero(zr_s[2])
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h expected=%h", nm, i, act, exp);
    end
  endtask

  task automatic chk1(input int i, input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%b expected=%b", nm, i, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Wait for done with a bounded budget; returns edges counted since the accepting edge.
  task automatic wait_done(input int i, output int cyc);
    cyc = 1;
    while (done_s[i] !== 1'b1 && cyc < nv[i] + 5) begin
      step;
      cyc++;
    end
  endtask

  task automatic check_results(input int i, input logic [63:0] d, input logic eb, input logic eo, input logic ez);
    chk (i, "diff",       diff_s[i], d);
    chk1(i, "borrow_out", bo_s[i],   eb);
    chk1(i, "overflow",   ov_s[i],   eo);
    chk1(i, "zero",       zr_s[i],   ez);
    chk1(i, "busy_in_done", busy_s[i], 1'b0);
  endtask

  // One operation; with keep=1 the task returns while still in the DONE cycle.
  task automatic run_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic [63:0] d,
                        input logic eb, input logic eo, input logic ez, input bit keep);
    int cyc;
    a_s[i] = a;
    b_s[i] = b;
    start_s[i] = 1'b1;
    step;
    start_s[i] = 1'b0;
    a_s[i] = ~a;
    b_s[i] = a ^ b ^ 64'h5A5A_0F0F_3C3C_9696;
    chk1(i, "busy_after_accept", busy_s[i], 1'b1);
    wait_done(i, cyc);
    chk(i, "done_latency", 64'(cyc), 64'(nv[i] + 1));
    check_results(i, d, eb, eo, ez);
    if (!keep) begin
      step;
      chk1(i, "done_pulse_width", done_s[i], 1'b0);
    end
  endtask

  task automatic held_start(input int i);
    int cyc;
    a_s[i] = 64'd100;
    b_s[i] = 64'd58;
    start_s[i] = 1'b1;
    step;
    chk1(i, "held_busy", busy_s[i], 1'b1);
    cyc = 1;
    while (done_s[i] !== 1'b1 && cyc < nv[i] + 5) begin
      a_s[i] = rnd64();
      b_s[i] = rnd64();
      step;
      cyc++;
    end
    chk(i, "held_latency", 64'(cyc), 64'(nv[i] + 1));
    check_results(i, 64'd42, 1'b0, 1'b0, 1'b0);
    a_s[i] = 64'd7;
    b_s[i] = 64'd10;
    step;
    start_s[i] = 1'b0;
    a_s[i] = rnd64();
    chk1(i, "held_b2b_busy", busy_s[i], 1'b1);
    wait_done(i, cyc);
    chk(i, "held_b2b_latency", 64'(cyc), 64'(nv[i] + 1));
    check_results(i, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b0);
    step;
    chk1(i, "held_done_low", done_s[i], 1'b0);
  endtask

  task automatic abort_test(input int i);
    int seen;
    a_s[i] = 64'd123;
    b_s[i] = 64'd45;
    start_s[i] = 1'b1;
    step;
    start_s[i] = 1'b0;
    for (int k = 1; k < nv[i] / 2; k++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk1(i, "abort_busy",   busy_s[i], 1'b0);
    chk1(i, "abort_done",   done_s[i], 1'b0);
    chk (i, "abort_diff",   diff_s[i], 64'd0);
    chk1(i, "abort_borrow", bo_s[i],   1'b0);
    chk1(i, "abort_ovf",    ov_s[i],   1'b0);
    chk1(i, "abort_zero",   zr_s[i],   1'b0);
    seen = 0;
    for (int k = 0; k < nv[i] + 3; k++) begin
      step;
      if (done_s[i] === 1'b1) seen++;
    end
    chk(i, "abort_no_done", 64'(seen), 64'd0);
    run_op(i, 64'd123, 64'd45, 64'd78, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic random_ops(input int i);
    logic [63:0] ra, rb, rd;
    for (int k = 0; k < rn[i]; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 64'd0;
        1:       ra = ~64'd0;
        default: ra = rnd64();
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 64'd0;
        1:       rb = ~64'd0;
        default: rb = rnd64();
      endcase
      rd = ra - rb;
      run_op(i, ra, rb, rd, (ra < rb), (ra[63] != rb[63]) && (rd[63] != ra[63]), (rd == 64'd0), 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{a: 64'd5, b: 64'd3, d: 64'd2, bo: 1'b0, ov: 1'b0, zr: 1'b0};
    vecs[1] = '{a: 64'd0, b: 64'd1, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1, ov: 1'b0, zr: 1'b0};
    vecs[2] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, d: 64'h7FFF_FFFF_FFFF_FFFF, bo: 1'b0, ov: 1'b1, zr: 1'b0};
    vecs[3] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, d: 64'h8000_0000_0000_0000, bo: 1'b1, ov: 1'b1, zr: 1'b0};
    vecs[4] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd0, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b0, ov: 1'b0, zr: 1'b0};
    vecs[5] = '{a: 64'd0, b: 64'd0, d: 64'd0, bo: 1'b0, ov: 1'b0, zr: 1'b1};
    vecs[6] = '{a: 64'd0, b: 64'h8000_0000_0000_0000, d: 64'h8000_0000_0000_0000, bo: 1'b1, ov: 1'b1, zr: 1'b0};
    vecs[7] = '{a: 64'd1000, b: 64'd1, d: 64'd999, bo: 1'b0, ov: 1'b0, zr: 1'b0};

    rst = 1'b1;
    start_s = 3'b111;
    a_s = '0;
    b_s = '0;
    step;
    step;
    for (int i = 0; i < 3; i++) begin
      chk1(i, "reset_busy",   busy_s[i], 1'b0);
      chk1(i, "reset_done",   done_s[i], 1'b0);
      chk (i, "reset_diff",   diff_s[i], 64'd0);
      chk1(i, "reset_borrow", bo_s[i],   1'b0);
      chk1(i, "reset_ovf",    ov_s[i],   1'b0);
      chk1(i, "reset_zero",   zr_s[i],   1'b0);
    end
    start_s = 3'b000;
    rst = 1'b0;
    step;

    for (int i = 0; i < 3; i++) begin
      for (int v = 0; v < 8; v++) begin
        run_op(i, vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].bo, vecs[v].ov, vecs[v].zr, 1'b0);
      end
      run_op(i, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      run_op(i, 64'd9, 64'd4, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      held_start(i);
      abort_test(i);
      random_ops(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
